// File: rtl/prog_loader.sv
// Program loader and run monitor: streams words into byte-wide instruction memory, then releases the core and watches for pass/timeout.
// Optional macro PROG_LOADER_CKSUM_EN enables the XOR checksum of accepted words (cksum held at 0 otherwise).
module prog_loader #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_WATCH      = 2,
    parameter int TIMEOUT_CYCLES = 125000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [ADDR_W-1:0]           s_addr,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_last,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [7:0]                  mem_wdata,
    output logic                        core_rst,
    input  logic [NUM_WATCH*DATA_W-1:0] watch_val,
    input  logic [NUM_WATCH*DATA_W-1:0] watch_exp,
    output logic [31:0]                 cycle_count,
    output logic [31:0]                 load_count,
    output logic [DATA_W-1:0]           cksum,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout
);

    localparam int BYTES = DATA_W / 8;
    localparam int K_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, RUN, DONE} state_t;

    state_t            state;
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              accept;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic all_match(input logic [NUM_WATCH*DATA_W-1:0] v,
                                       input logic [NUM_WATCH*DATA_W-1:0] e);
        logic m;
        m = 1'b1;
        for (int i = 0; i < NUM_WATCH; i++)
            if (v[i*DATA_W +: DATA_W] != e[i*DATA_W +: DATA_W]) m = 1'b0;
        return m;
    endfunction

    assign accept = (state == IDLE) && s_valid && s_ready;

    // Word buffer: the address walks and the data shifts down one byte per write.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= s_addr;
            data_q <= s_data;
            last_q <= s_last;
        end else if (state == WRITE) begin
            addr_q <= addr_q + ADDR_W'(1);
            data_q <= data_q >> 8;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= '0;
            s_ready     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            core_rst    <= 1'b1;
            cycle_count <= '0;
            load_count  <= '0;
            cksum       <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (accept) begin
                        s_ready    <= 1'b0;
                        load_count <= load_count + 32'd1;
`ifdef PROG_LOADER_CKSUM_EN
                        cksum      <= cksum ^ s_data;
`endif
                        k          <= '0;
                        state      <= WRITE;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= data_q[7:0];
                    k         <= k + K_W'(1);
                    if (k == K_W'(BYTES - 1)) begin
                        if (last_q) begin
                            state <= RUN;
                        end else begin
                            state   <= IDLE;
                            s_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    mem_we <= 1'b0;
                    // The first RUN cycle only releases the core; watches count from the next one.
                    if (core_rst) begin
                        core_rst <= 1'b0;
                    end else if (all_match(watch_val, watch_exp)) begin
                        done  <= 1'b1;
                        pass  <= 1'b1;
                        state <= DONE;
                    end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cycle_count <= sat_inc(cycle_count);
                    end
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected byte writes and run results are queued at stimulus time and checked by a monitor.
module tb_prog_loader;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NW    = 2;
    localparam int T     = 48;
    localparam int BYTES = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             s_valid, s_ready, s_last;
    logic [AW-1:0]    s_addr, mem_addr;
    logic [DW-1:0]    s_data, cksum;
    logic             mem_we;
    logic [7:0]       mem_wdata;
    logic             core_rst;
    logic [NW*DW-1:0] watch_val, watch_exp;
    logic [31:0]      cycle_count, load_count;
    logic             done, pass, timeout;

    prog_loader #(.ADDR_W(AW), .DATA_W(DW), .NUM_WATCH(NW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst(core_rst), .watch_val(watch_val),
        .watch_exp(watch_exp), .cycle_count(cycle_count), .load_count(load_count),
        .cksum(cksum), .done(done), .pass(pass), .timeout(timeout)
    );

    typedef struct { logic [31:0] addr; logic [7:0] data; int at; } wr_t;
    typedef struct { logic ps; logic tm; int cnt; int at; } res_t;

    wr_t        wq[$];
    res_t       rq[$];
    wr_t        w;
    res_t       r;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic       done_d = 1'b0;
    int         exp_load;
    logic [DW-1:0] exp_ck;
    int         hs, h0, h1, h2;
    int         nw;
    logic [31:0] base;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ck_exp();
`ifdef PROG_LOADER_CKSUM_EN
        return exp_ck;
`else
        return '0;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every byte write and every rising done is matched against the queues.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_we) begin
                check("write_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                    check("wr_cycle", cyc, w.at);
                end
            end
            if (done && !done_d) begin
                check("result_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    check("res_pass", pass, r.ps);
                    check("res_timeout", timeout, r.tm);
                    check("res_count", cycle_count, r.cnt);
                    check("res_cycle", cyc, r.at);
                end
            end
        end
        done_d <= done;
    end

    task automatic reset_assert();
        rst = 1'b0;
        s_valid = 1'b0;
        wq.delete();
        rq.delete();
        exp_load = 0;
        exp_ck = '0;
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_load_count", load_count, 0);
        check("rst_cksum", cksum, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
    endtask

    task automatic reset_release();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s_ready_rise", s_ready, 1);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic l, output int h);
        int n = 0;
        s_addr  = a;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bound", n < 40, 1);
        h = cyc + 1;
        for (int k = 0; k < BYTES; k++)
            wq.push_back('{addr: a + 32'(k), data: d[8*k +: 8], at: h + 1 + k});
        exp_load++;
        exp_ck ^= d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input int last_h);
        int n = 0;
        while (core_rst !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("run_wait_bound", n < 100, 1);
        check("core_rst_fall_cycle", cyc, last_h + BYTES + 1);
    endtask

    task automatic drive_watch(input logic m, input logic [63:0] e);
        int sel;
        if (m) begin
            watch_val = e;
        end else begin
            sel = $urandom_range(0, 2);
            watch_val[31:0]  = (sel == 0) ? e[31:0]  : e[31:0]  ^ ($urandom | 32'd1);
            watch_val[63:32] = (sel == 1) ? e[63:32] : e[63:32] ^ ($urandom | 32'd1);
        end
    endtask

    // Called at run cycle 0; mj < 0 or mj >= T means the watches never match.
    task automatic do_run(input int mj, input logic [63:0] e);
        int   cnt;
        logic ep;
        ep  = (mj >= 0 && mj < T);
        cnt = ep ? mj : T - 1;
        rq.push_back('{ps: ep, tm: !ep, cnt: cnt, at: cyc + cnt + 1});
        for (int j = 0; j <= cnt; j++) begin
            drive_watch(j == mj, e);
            check("run_count", cycle_count, j);
            check("run_not_done", done, 0);
            check("run_core_rst", core_rst, 0);
            @(negedge clk);
        end
        repeat (4) begin
            drive_watch($urandom_range(0, 1) == 1, e);
            check("frozen_count", cycle_count, cnt);
            check("done_held", done, 1);
            check("pass_held", pass, ep);
            check("timeout_held", timeout, !ep);
            check("core_rst_held", core_rst, 0);
            check("s_ready_done", s_ready, 0);
            @(negedge clk);
        end
        check("results_drained", rq.size(), 0);
        check("writes_drained", wq.size(), 0);
        check("load_count", load_count, exp_load);
        check("cksum", cksum, ck_exp());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog bench did not finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_last = 1'b0;
        watch_val = '0; watch_exp = '0;
        #3;
        reset_assert();
        reset_release();

        // Single word, pass at run cycle 40; watches matching during load must be ignored.
        watch_exp = {32'd69, 32'd1234};
        watch_val = watch_exp;
        send_word(32'h0, 32'h0050_0113, 1'b1, hs);
        s_valid = 1'b0;
        wait_run(hs);
        do_run(40, watch_exp);

        // Three back-to-back words, stream held valid afterwards, timeout.
        reset_assert();
        reset_release();
        watch_exp = {$urandom, $urandom};
        watch_val = ~watch_exp;
        send_word(32'h0, $urandom, 1'b0, h0);
        send_word(32'h4, $urandom, 1'b0, h1);
        send_word(32'h8, $urandom, 1'b1, h2);
        check("gap1", h1 - h0, BYTES + 1);
        check("gap2", h2 - h1, BYTES + 1);
        s_addr = 32'h100; s_data = $urandom; s_last = 1'b0;
        wait_run(h2);
        do_run(-1, watch_exp);
        s_valid = 1'b0;

        // Address wrap at the top of the space, match on the final allowed cycle.
        reset_assert();
        reset_release();
        watch_exp = {$urandom, $urandom};
        send_word(32'hFFFF_FFFE, $urandom, 1'b1, hs);
        s_valid = 1'b0;
        wait_run(hs);
        do_run(T - 1, watch_exp);

        // Reset while byte 2 of a word is being written, then a clean reload.
        reset_assert();
        reset_release();
        send_word(32'h40, $urandom, 1'b0, hs);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_assert();
        reset_release();
        watch_exp = {$urandom, $urandom};
        send_word(32'h80, $urandom, 1'b0, hs);
        send_word(32'h84, $urandom, 1'b1, hs);
        s_valid = 1'b0;
        wait_run(hs);
        do_run($urandom_range(0, T - 2), watch_exp);

        // Random programs with idle gaps and random match cycles.
        for (int it = 0; it < 4; it++) begin
            reset_assert();
            reset_release();
            watch_exp = {$urandom, $urandom};
            watch_val = watch_exp;
            nw   = $urandom_range(1, 3);
            base = $urandom;
            for (int i = 0; i < nw; i++) begin
                send_word(base + 32'(4 * i), $urandom, i == nw - 1, hs);
                if ($urandom_range(0, 1) == 1 || i == nw - 1) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
            wait_run(hs);
            do_run($urandom_range(0, T + 4), watch_exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
